// File: rtl/mem_access.sv
// Memory-access stage: runs load/store on a req/ack bus, passes other results through.
// Optional MEM_MISALIGN_TRAP_EN adds a misaligned output and skips the bus for misaligned accesses.
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data,
  input  logic [4:0]        dest_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_dest,
  output logic [31:0]       wb_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_dest_q, wb_dest_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [2:0]          func3_q, func3_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [4:0]          dest_q, dest_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                misaligned_q, misaligned_d;
  logic                misalign_in;
`endif

  logic                is_byte_in, is_half_in;
  logic                mem_op_in;
  logic [31:0]         st_wdata;
  logic [3:0]          st_wstrb;
  logic [31:0]         load_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  assign is_byte_in = (func3[1:0] == 2'b00);
  assign is_half_in = (func3[1:0] == 2'b01);
  assign mem_op_in  = is_load | is_store;

  // Store lane replication and byte enables from size code and low address bits.
  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    if (is_byte_in) begin
      st_wdata = {4{store_data[7:0]}};
      st_wstrb = 4'b0001 << addr_i[1:0];
    end else if (is_half_in) begin
      st_wdata = {2{store_data[15:0]}};
      st_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_in = (is_half_in && addr_i[0]) ||
                       (!is_byte_in && !is_half_in && (addr_i[1:0] != 2'b00));
`endif

  // Load lane extraction uses the size/address captured at accept time.
  always_comb begin
    ld_byte = 8'h00;
    case (addr_lo_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    if (func3_q[1:0] == 2'b00) begin
      load_data = func3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (func3_q[1:0] == 2'b01) begin
      load_data = func3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_valid_d  = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    func3_d     = func3_q;
    addr_lo_d   = addr_lo_q;
    dest_d      = dest_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!mem_op_in) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = dest_i;
            wb_data_d  = addr_i;
`ifdef MEM_MISALIGN_TRAP_EN
          end else if (misalign_in) begin
            wb_valid_d   = 1'b1;
            misaligned_d = 1'b1;
            wb_dest_d    = 5'd0;
            wb_data_d    = addr_i;
`endif
          end else begin
            // A load+store combination is treated as a store.
            state_d     = WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
            func3_d     = func3;
            addr_lo_d   = addr_i[1:0];
            dest_d      = dest_i;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          wb_valid_d  = 1'b1;
          wb_dest_d   = mem_we_q ? 5'd0 : dest_q;
          wb_data_d   = mem_we_q ? 32'd0 : load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_data_q   <= 32'd0;
      func3_q     <= 3'd0;
      addr_lo_q   <= 2'd0;
      dest_q      <= 5'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      func3_q     <= func3_d;
      addr_lo_q   <= addr_lo_d;
      dest_q      <= dest_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; inputs change and outputs are sampled 1ns after posedge.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] addr_i;
  logic [31:0] store_data;
  logic [4:0]  dest_i;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int total = 0;
  int bad = 0;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .is_load(is_load), .is_store(is_store), .func3(func3), .addr_i(addr_i),
    .store_data(store_data), .dest_i(dest_i), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .wb_dest(wb_dest), .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
    valid_i = 1'b1; is_load = ld; is_store = st; func3 = f3;
    addr_i = a; store_data = sd; dest_i = d;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; is_load = 1'b0; is_store = 1'b0; func3 = 3'd0;
    addr_i = 32'd0; store_data = 32'd0; dest_i = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs(); mem_ack = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", mem_req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wbv got %b want 0", wb_valid); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", ready_o); end
    total++; if ({mem_addr, mem_wdata, wb_data} !== 96'd0) begin bad++; $display("FAIL rst_data got %h %h %h want 0", mem_addr, mem_wdata, wb_data); end
    total++; if ({mem_wstrb, wb_dest, mem_we} !== 10'd0) begin bad++; $display("FAIL rst_misc got %b %h %b want 0", mem_wstrb, wb_dest, mem_we); end
    reset = 1'b1;
    tick();
    // Reset in the middle of a wait, then a late ack must be ignored.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd3);
    tick(); idle_inputs();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstw_req_pre got %b want 1", mem_req); end
    reset = 1'b0;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstw_req got %b want 0", mem_req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstw_wbv got %b want 0", wb_valid); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rstw_ready got %b want 1", ready_o); end
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick(); mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstw_lateack got %b want 0", wb_valid); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstw_lateack2 got %b want 0", wb_valid); end
  endtask

  task automatic test_passthrough();
    drive_op(1'b0, 1'b0, 3'd0, 32'd24, 32'd0, 5'd9);
    tick(); idle_inputs();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL pt_wbv got %b want 1", wb_valid); end
    total++; if (wb_data !== 32'd24) begin bad++; $display("FAIL pt_data got %h want 18", wb_data); end
    total++; if (wb_dest !== 5'd9) begin bad++; $display("FAIL pt_dest got %0d want 9", wb_dest); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL pt_req got %b want 0", mem_req); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL pt_pulse got %b want 0", wb_valid); end
  endtask

  task automatic test_lb_signed();
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7);
    tick(); idle_inputs();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lb_req got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL lb_addr got %h want 100", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL lb_we got %b want 0", mem_we); end
    total++; if (mem_wstrb !== 4'b0000) begin bad++; $display("FAIL lb_wstrb got %b want 0000", mem_wstrb); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL lb_ready got %b want 0", ready_o); end
    // Upstream offers a new op while busy; it must be ignored.
    drive_op(1'b0, 1'b0, 3'd0, 32'hDEAD, 32'd0, 5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || wb_valid !== 1'b0) begin
        bad++; $display("FAIL lb_hold%0d got req=%b addr=%h wbv=%b want 1 100 0", i, mem_req, mem_addr, wb_valid);
      end
    end
    idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    tick(); mem_ack = 1'b0; mem_rdata = 32'd0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lb_wbv got %b want 1", wb_valid); end
    total++; if (wb_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got %h want ffffff80", wb_data); end
    total++; if (wb_dest !== 5'd7) begin bad++; $display("FAIL lb_dest got %0d want 7", wb_dest); end
    total++; if (mem_req !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL lb_done got req=%b rdy=%b want 0 1", mem_req, ready_o); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lb_pulse got %b want 0", wb_valid); end
  endtask

  task automatic test_lhu_lh();
    drive_op(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0, 5'd12);
    tick(); idle_inputs();
    total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL lhu_addr got %h want 200", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hBEEF_0011;
    tick(); mem_ack = 1'b0;
    total++; if (wb_data !== 32'h0000_BEEF || wb_dest !== 5'd12) begin bad++; $display("FAIL lhu_data got %h/%0d want 0000beef/12", wb_data, wb_dest); end
    // Signed half, low lane.
    drive_op(1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'd0, 5'd4);
    tick(); idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'h1111_8001;
    tick(); mem_ack = 1'b0;
    total++; if (wb_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got %h want ffff8001", wb_data); end
    // Unsigned byte, lane 1.
    drive_op(1'b1, 1'b0, 3'b100, 32'h0000_0301, 32'd0, 5'd5);
    tick(); idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'h0000_F300;
    tick(); mem_ack = 1'b0;
    total++; if (wb_data !== 32'h0000_00F3) begin bad++; $display("FAIL lbu_data got %h want 000000f3", wb_data); end
  endtask

  task automatic test_stores();
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 5'd6);
    tick(); idle_inputs();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL sh_req got %b/%b want 1/1", mem_req, mem_we); end
    total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL sh_addr got %h want 40", mem_addr); end
    total++; if (mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got %h want abcdabcd", mem_wdata); end
    total++; if (mem_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got %b want 1100", mem_wstrb); end
    tick();
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_dest !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL sh_wb got %b/%0d/%h want 1/0/0", wb_valid, wb_dest, wb_data); end
    total++; if (mem_wstrb !== 4'b0000 || mem_we !== 1'b0) begin bad++; $display("FAIL sh_idle got %b/%b want 0000/0", mem_wstrb, mem_we); end
    // Byte store, lane 1.
    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_775A, 5'd2);
    tick(); idle_inputs();
    total++; if (mem_wdata !== 32'h5A5A_5A5A || mem_wstrb !== 4'b0010) begin bad++; $display("FAIL sb got %h/%b want 5a5a5a5a/0010", mem_wdata, mem_wstrb); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    // Load and store both set acts as a word store.
    drive_op(1'b1, 1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D, 5'd8);
    tick(); idle_inputs();
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || mem_wstrb !== 4'b1111) begin bad++; $display("FAIL sw_both got %b/%h/%b want 1/cafef00d/1111", mem_we, mem_wdata, mem_wstrb); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555; tick(); mem_ack = 1'b0;
    total++; if (wb_dest !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL sw_both_wb got %0d/%h want 0/0", wb_dest, wb_data); end
  endtask

  task automatic test_misaligned();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 5'd11);
    tick(); idle_inputs();
`ifdef MEM_MISALIGN_TRAP_EN
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_req got %b want 0", mem_req); end
    total++; if (wb_valid !== 1'b1 || misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag got %b/%b want 1/1", wb_valid, misaligned); end
    total++; if (wb_dest !== 5'd0 || wb_data !== 32'h101) begin bad++; $display("FAIL mis_wb got %0d/%h want 0/101", wb_dest, wb_data); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mis_ready got %b want 1", ready_o); end
    tick();
    total++; if (misaligned !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL mis_after got %b/%b want 0/0", misaligned, mem_req); end
`else
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL mis_req got %b/%h want 1/100", mem_req, mem_addr); end
    total++; if (mem_wstrb !== 4'b0000) begin bad++; $display("FAIL mis_wstrb got %b want 0000", mem_wstrb); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_dest !== 5'd11) begin bad++; $display("FAIL mis_wb got %b/%h/%0d want 1/deadbeef/11", wb_valid, wb_data, wb_dest); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h0000_0001; vals[1] = 32'hFFFF_0000; vals[2] = 32'h8765_4321;
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b0, 1'b0, 3'd0, vals[i], 32'd0, 5'(i + 20));
      tick();
      total++; if (wb_valid !== 1'b1 || wb_data !== vals[i] || wb_dest !== 5'(i + 20)) begin
        bad++; $display("FAIL b2b%0d got %b/%h/%0d want 1/%h/%0d", i, wb_valid, wb_data, wb_dest, vals[i], i + 20);
      end
    end
    idle_inputs();
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got %b want 0", wb_valid); end
  endtask

  task automatic test_idle_ack();
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick(); mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL idle_ack got %b/%b/%b want 0/0/1", wb_valid, mem_req, ready_o); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb_signed();
    test_lhu_lh();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_idle_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute unit.
- Consumes execute's result (effective address or ALU/jump result), destination register, load/store flags and func3.
- Runs load/store transactions on a simple req/ack data-memory bus and presents a single writeback beat to the register file.
- Non-memory results pass through with one cycle of latency.

Parameters:
- ADDR_W, 32, data-memory address width (bits of addr_i driven onto mem_addr).

Ports:
- clk  in  1  stage clock, all state on rising edge
- reset  in  1  synchronous reset, active-low (0 = reset)
- valid_i  in  1  execute output valid this cycle
- ready_o  out  1  stage can accept; high only in IDLE
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- func3  in  3  access size/sign code from decode
- addr_i  in  32  execute result: effective address for load/store, writeback value otherwise
- store_data  in  32  rs2 value for stores
- dest_i  in  5  destination register from execute
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
- mem_wdata  out  32  store data replicated into lanes
- mem_wstrb  out  4  byte-lane write enables
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  transaction complete, single-cycle pulse
- wb_valid  out  1  one-cycle writeback pulse
- wb_dest  out  5  writeback register (0 = no write)
- wb_data  out  32  writeback value

Behaviour:
- Reset (reset==0 at edge): state IDLE; mem_req, mem_we, wb_valid = 0; mem_addr, mem_wdata, wb_data = 0; mem_wstrb = 0; wb_dest = 0; any in-flight transaction abandoned, a later mem_ack ignored.
- States: IDLE, WAIT.
- IDLE, valid_i && !is_load && !is_store: next cycle wb_valid=1, wb_data=addr_i, wb_dest=dest_i; stay IDLE.
- IDLE, valid_i && (is_load||is_store): latch inputs, go WAIT; next cycle mem_req=1, mem_we=is_store, mem_addr={addr_i[ADDR_W-1:2],2'b00}.
  - If is_load and is_store are both set, the access is treated as a store.
- WAIT: all mem_* outputs held stable until mem_ack sampled high. On the ack edge: mem_req=0, mem_we=0, state IDLE, wb_valid=1 for exactly one cycle.
- Load result: wb_dest=latched dest; wb_data extracted from mem_rdata.
- Store result: wb_dest=0, wb_data=0.
- Size by func3:
  - 000 byte signed, 100 byte unsigned: lane addr[1:0].
  - 001 half signed, 101 half unsigned: lane addr[1] (bytes 0-1 or 2-3).
  - 010, and reserved 011/110/111: word.
- Loads sign- or zero-extend the selected lane to 32 bits.
- Stores:
  - byte: mem_wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0]
  - half: mem_wdata={2{sd[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011
  - word: mem_wdata=sd, wstrb=4'b1111
  - wstrb=0 whenever mem_req=0.
- Latency: accept at edge N, mem_req high from N+1; ack at N+k gives wb_valid during N+k+1 (minimum 2 cycles).
- ready_o=0 throughout WAIT; valid_i ignored while not ready. Upstream holds its instruction.
- mem_ack while in IDLE: ignored.
- Back-to-back pass-through ops: one writeback per cycle, no bubble.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, never raises mem_req.
  - Next cycle: wb_valid=1, misaligned=1, wb_dest=0, wb_data=addr_i; state remains IDLE.
- Undefined: port absent; low address bits are ignored per the lane rules above (access silently aligned).

Test Plan:
- Reset: hold reset=0 two cycles mid-WAIT with mem_req high -> mem_req=0, wb_valid=0, ready_o=1; ack one cycle later produces no wb_valid.
- Pass-through: valid_i, addr_i=24, dest_i=9, no load/store -> next cycle wb_valid=1, wb_data=24, wb_dest=9.
- LB signed: addr_i=0x103, ack after 3 wait cycles with mem_rdata=0x80FF_1234 -> mem_addr=0x100; wb_data=0xFFFF_FF80, wb_dest=dest_i, wb_valid one cycle.
- LHU: addr_i=0x202, mem_rdata=0xBEEF_0011 -> wb_data=0x0000_BEEF.
- SH: addr_i=0x42, store_data=0x1234_ABCD -> mem_we=1, mem_addr=0x40, mem_wdata=0xABCD_ABCD, mem_wstrb=4'b1100; wb_dest=0 after ack.
- Misaligned LW at 0x101: macro on -> misaligned=1, mem_req never high; macro off -> mem_addr=0x100, wstrb=0, normal load.
